// File: rtl/riscv_div_ctrl_if.sv
// Handshake bundle between the EX stage and the iterative divider.
// master: EX-side driver of operands/controls; slave: divider sequencer.
interface riscv_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             enable_i;
    logic [1:0]       operator_i;
    logic [WIDTH-1:0] op_a_i;
    logic [WIDTH-1:0] op_b_i;
    logic             tag_a_i;
    logic             tag_b_i;
    logic             flush_i;
    logic             ex_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             tag_o;
    logic             ready_o;
    logic             busy_o;

    modport master (
        output enable_i, operator_i, op_a_i, op_b_i,
        output tag_a_i, tag_b_i, flush_i, ex_ready_i,
        input  result_o, tag_o, ready_o, busy_o
    );

    modport slave (
        input  enable_i, operator_i, op_a_i, op_b_i,
        input  tag_a_i, tag_b_i, flush_i, ex_ready_i,
        output result_o, tag_o, ready_o, busy_o
    );
endinterface

// File: rtl/riscv_div_ctrl.sv
// Sequencer for the shared radix-2 restoring divider in EX (DIV/DIVU/REM/REMU).
// Ports: clk, rst_n (async low), div (slave bundle: operands, flush, ex_ready, result, tag, ready, busy).
module riscv_div_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    riscv_div_ctrl_if.slave div
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             is_rem_q, is_rem_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             tag_q, tag_d;

    logic             start;
    logic             sgn, a_neg, b_neg, div_zero, ovf;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] rem_n, quo_n;

    // Operand conditioning at start: magnitudes only for signed ops.
    always_comb begin
        sgn      = div.operator_i[0];
        a_neg    = sgn & div.op_a_i[WIDTH-1];
        b_neg    = sgn & div.op_b_i[WIDTH-1];
        a_abs    = a_neg ? (WIDTH'(0) - div.op_a_i) : div.op_a_i;
        b_abs    = b_neg ? (WIDTH'(0) - div.op_b_i) : div.op_b_i;
        div_zero = (div.op_b_i == '0);
        ovf      = sgn & (div.op_a_i == MIN_NEG) & (div.op_b_i == '1);
        start    = (state_q == IDLE) & div.enable_i & ~div.flush_i;
    end

    // One restoring step: the shifted partial remainder is WIDTH+1 bits wide.
    always_comb begin
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
        if (!trial[WIDTH]) begin
            rem_n = trial[WIDTH-1:0];
            quo_n = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_n = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_n = {quo_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            is_rem_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            tag_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            is_rem_q <= is_rem_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            tag_q    <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (div.flush_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    if (div.enable_i) state_d = (div_zero | ovf) ? FINISH : CALC;
                CALC:    if (cnt_q == '0) state_d = FINISH;
                FINISH:  if (div.ex_ready_i) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        is_rem_d = is_rem_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        tag_d    = tag_q;
        if (div.flush_i) begin
            cnt_d    = '0;
            result_d = '0;
            tag_d    = 1'b0;
        end else if (start) begin
            rem_d    = '0;
            quo_d    = a_abs;
            dvs_d    = b_abs;
            is_rem_d = div.operator_i[1];
            qneg_d   = a_neg ^ b_neg;
            rneg_d   = a_neg;
            tag_d    = div.tag_a_i | div.tag_b_i;
            cnt_d    = CNT_W'(WIDTH - 1);
            // Special cases bypass the loop entirely.
            if (div_zero) begin
                result_d = div.operator_i[1] ? div.op_a_i : '1;
            end else if (ovf) begin
                result_d = div.operator_i[1] ? '0 : MIN_NEG;
            end
        end else if (state_q == CALC) begin
            rem_d = rem_n;
            quo_d = quo_n;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
                cnt_d = '0;
                if (is_rem_q) begin
                    result_d = rneg_q ? (WIDTH'(0) - rem_n) : rem_n;
                end else begin
                    result_d = qneg_q ? (WIDTH'(0) - quo_n) : quo_n;
                end
            end
        end
    end

    always_comb begin
        div.ready_o  = ((state_q == IDLE) & ~div.enable_i) | (state_q == FINISH);
        div.busy_o   = (state_q == CALC) | (state_q == FINISH);
        div.result_o = result_q;
        div.tag_o    = tag_q;
    end
endmodule
